// File: rtl/led_blink_arbiter.sv
// led_blink_arbiter: round-robin owner of the single board LED.
// Each granted requester gets its blink code played as N timed on/off
// pulses followed by a dark gap; the code runs to completion before the
// next arbitration.
module led_blink_arbiter #(
  parameter int DIV       = 1000,  // clk cycles per tick
  parameter int ON_TICKS  = 2,     // ticks high per blink
  parameter int OFF_TICKS = 2,     // ticks low between blinks
  parameter int GAP_TICKS = 6,     // ticks low after the last blink
  parameter int NREQ      = 4,     // number of requesters
  parameter int CW        = 4      // blink-count field width
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*CW-1:0]   count,
  output logic                 led,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

  // Longest phase sets the tick counter width; prescaler holds DIV-1.
  localparam int TMAX = (ON_TICKS > OFF_TICKS)
                        ? ((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS)
                        : ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
  localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int LW = $clog2(NREQ);

  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_TICKS - 1);
  localparam logic [LW-1:0] LAST_RST = LW'(NREQ - 1);

  state_t          state, state_n;
  logic [PW-1:0]   pre, pre_n;
  logic [TW-1:0]   tcnt, tcnt_n;
  logic [CW-1:0]   rem, rem_n;
  logic [LW-1:0]   last, last_n;
  logic [NREQ-1:0] grant_n;
  logic            led_n, done_n;
  logic            tick;
  logic            found;
  logic [LW-1:0]   pick;

  assign tick = (pre == PRE_LAST);
  assign busy = |grant;

  // Round-robin pick: first asserted request scanning from last+1 upward.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // through the block can leave it holding a value (which would be a latch).
    found = 1'b0;
    pick  = last;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && req[(int'(last) + i) % NREQ]) begin
        found = 1'b1;
        pick  = LW'((int'(last) + i) % NREQ);
      end
    end
  end

  // Next-state, phase timing and next output values.
  always_comb begin
    state_n = state;
    pre_n   = pre;
    tcnt_n  = tcnt;
    rem_n   = rem;
    last_n  = last;
    grant_n = grant;
    done_n  = 1'b0;

    case (state)
      IDLE: begin
        if (found) begin
          grant_n = NREQ'(1) << pick;
          last_n  = pick;
          rem_n   = count[int'(pick)*CW +: CW];
          // A zero-length code skips straight to the dark gap.
          state_n = (count[int'(pick)*CW +: CW] != '0) ? ON : GAP;
        end
      end
      ON: begin
        if (tick && tcnt == ON_LAST) begin
          rem_n   = rem - CW'(1);
          state_n = (rem == CW'(1)) ? GAP : OFF;
        end
      end
      OFF: begin
        if (tick && tcnt == OFF_LAST) state_n = ON;
      end
      GAP: begin
        if (tick && tcnt == GAP_LAST) begin
          state_n = IDLE;
          grant_n = '0;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Prescaler and tick counter restart on every state entry.
    if (state_n != state) begin
      pre_n  = '0;
      tcnt_n = '0;
    end else if (state != IDLE) begin
      if (tick) begin
        pre_n  = '0;
        tcnt_n = tcnt + TW'(1);
      end else begin
        pre_n  = pre + PW'(1);
      end
    end

    // LED follows the ON state exactly, registered with it.
    led_n = (state_n == ON);
  end

  // State and output registers; reset drops any code in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pre   <= '0;
      tcnt  <= '0;
      rem   <= '0;
      last  <= LAST_RST;
      grant <= '0;
      led   <= 1'b0;
      done  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state <= state_n;
      pre   <= pre_n;
      tcnt  <= tcnt_n;
      rem   <= rem_n;
      last  <= last_n;
      grant <= grant_n;
      led   <= led_n;
      done  <= done_n;
    end
  end

endmodule
